// File: rtl/act_harness_pkg.sv
// Shared types and width helpers for the activation stream replay/capture harness.
package act_harness_pkg;

  // Run sequencing phases.
  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    FEED,
    DRAIN,
    TAIL,
    DONE
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Address width for a memory of the given depth (at least one bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold the values 0..n inclusive.
  function automatic int unsigned count_w(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // One phase counter serves every phase, so it is sized for the longest one.
  function automatic int unsigned phase_cnt_w(input int unsigned flush_c,
                                              input int unsigned feed_c,
                                              input int unsigned drain_c,
                                              input int unsigned tail_c);
    return count_w(max2(max2(flush_c, feed_c), max2(drain_c, tail_c)));
  endfunction

endpackage

// File: rtl/act_stream_harness_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module sdp_ram
  import act_harness_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/act_stream_harness.sv
// Replay/capture harness: streams stored activation words into the network,
// pads with zero-input drain cycles and idle tail cycles, and records every
// output word the network marks ready into a capture buffer.
module act_stream_harness
  import act_harness_pkg::*;
#(
  parameter int IN_W         = 16,
  parameter int OUT_W        = 96,
  parameter int IN_DEPTH     = 1024,
  parameter int OUT_DEPTH    = 256,
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 32,
  parameter int TAIL_CYCLES  = 50
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [$clog2(IN_DEPTH)-1:0]    load_addr,
  input  logic [IN_W-1:0]                load_data,
  input  logic [$clog2(IN_DEPTH+1)-1:0]  num_vectors,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           dut_valid,
  output logic                           dut_flush,
  output logic [IN_W-1:0]                dut_input_act,
  input  logic [OUT_W-1:0]               dut_output_act,
  input  logic                           dut_ready,
  input  logic [$clog2(OUT_DEPTH)-1:0]   rd_addr,
  output logic [OUT_W-1:0]               rd_data,
  output logic [$clog2(OUT_DEPTH+1)-1:0] out_count,
  output logic                           overflow
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int CAW = $clog2(OUT_DEPTH);
  localparam int NW  = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int CW  = phase_cnt_w(FLUSH_CYCLES, IN_DEPTH, DRAIN_CYCLES, TAIL_CYCLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   num_q, num_d;
  logic [IAW-1:0]  ptr_q, ptr_d;
  logic [OCW-1:0]  out_count_q, out_count_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic [IN_W-1:0] act_q, act_d;
  logic            fwd_hit_q, fwd_hit_d;
  logic [IN_W-1:0] fwd_data_q, fwd_data_d;

  logic            load_we;
  logic [IN_W-1:0] in_rdata;
  logic [IN_W-1:0] in_word;
  logic            cap_active;
  logic            cap_full;
  logic            cap_we;

  assign load_we = load_en && (state_q == IDLE);

  // A load in the start cycle can hit the address being read that same edge;
  // forward the new word so the first fed word is never stale.
  assign in_word = fwd_hit_q ? fwd_data_q : in_rdata;

  sdp_ram #(
    .WIDTH (IN_W),
    .DEPTH (IN_DEPTH)
  ) u_in_mem (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (ptr_d),
    .rdata (in_rdata)
  );

  sdp_ram #(
    .WIDTH (OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_cap_mem (
    .clk   (clk),
    .we    (cap_we),
    .waddr (out_count_q[CAW-1:0]),
    .wdata (dut_output_act),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Phase sequencing: each phase ends when its counter hits length-1 exactly.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          num_d   = num_vectors;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
          state_d = (num_q == '0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (cnt_q == (CW'(num_q) - CW'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        if (cnt_q == CW'(TAIL_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Phase counter restarts on every phase change and rests at zero in IDLE;
  // the read pointer runs one word ahead of the output register.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q != IDLE) && (state_q != DONE)) begin
      cnt_d = cnt_q + CW'(1);
    end
    ptr_d = '0;
    case (state_q)
      FLUSH:   ptr_d = (state_d == FEED) ? (ptr_q + IAW'(1)) : ptr_q;
      FEED:    ptr_d = ptr_q + IAW'(1);
      default: ptr_d = '0;
    endcase
  end

  // Capture of ready words while the network can be producing results.
  always_comb begin
    cap_active  = (state_q == FEED) || (state_q == DRAIN) || (state_q == TAIL);
    cap_full    = (out_count_q == OCW'(OUT_DEPTH));
    cap_we      = cap_active && dut_ready && !cap_full;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;
    if ((state_q == IDLE) && start) begin
      out_count_d = '0;
      overflow_d  = 1'b0;
    end else if (cap_active && dut_ready) begin
      if (cap_full) begin
        overflow_d = 1'b1;
      end else begin
        out_count_d = out_count_q + OCW'(1);
      end
    end
  end

  // Registered outputs derived from the phase of the coming cycle.
  always_comb begin
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
    valid_d    = (state_d == FEED) || (state_d == DRAIN);
    flush_d    = (state_d == IDLE) || (state_d == FLUSH);
    act_d      = (state_d == FEED) ? in_word : '0;
    fwd_hit_d  = load_we && (load_addr == ptr_d);
    fwd_data_d = load_data;
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      ptr_q       <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b1;
      act_q       <= '0;
      fwd_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      ptr_q       <= ptr_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      act_q       <= act_d;
      fwd_hit_q   <= fwd_hit_d;
    end
  end

  // Forwarded load word is only qualified by fwd_hit_q, so it needs no reset.
  always_ff @(posedge clk) begin
    fwd_data_q <= fwd_data_d;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dut_valid     = valid_q;
  assign dut_flush     = flush_q;
  assign dut_input_act = act_q;
  assign out_count     = out_count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_act_stream_harness.sv
// Bench for act_stream_harness: two instances (full-size and 4-entry capture)
// checked every cycle against a per-run expected schedule and a capture model.
module tb_act_stream_harness;

  localparam int IN_W = 16;
  localparam int OUT_W = 96;
  localparam int IN_DEPTH = 1024;
  localparam int DEP_A = 256;
  localparam int DEP_B = 4;
  localparam int FLUSH_C = 1;
  localparam int DRAIN_C = 32;
  localparam int TAIL_C = 50;

  typedef struct {
    bit valid; bit flush; bit fl_chk; bit busy; bit done;
    logic [IN_W-1:0] act; bit active; bit clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst, load_en, start, ready_a, ready_b;
  logic [9:0] load_addr;
  logic [IN_W-1:0] load_data;
  logic [10:0] num_vectors;
  logic [OUT_W-1:0] out_act;
  logic [7:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  logic busy_a, done_a, valid_a, flush_a, ovf_a;
  logic busy_b, done_b, valid_b, flush_b, ovf_b;
  logic [IN_W-1:0] act_a, act_b;
  logic [OUT_W-1:0] rd_data_a, rd_data_b;
  logic [8:0] cnt_a;
  logic [2:0] cnt_b;

  exp_t expq[$];
  exp_t ce;
  logic [IN_W-1:0] model_mem [IN_DEPTH];
  logic [OUT_W-1:0] cap_a [DEP_A];
  logic [OUT_W-1:0] cap_b [DEP_B];
  int mcnt_a = 0, mcnt_b = 0;
  bit mov_a = 0, mov_b = 0;
  int n_vec = 0, n_miss = 0;
  int rel = 0;
  int rdy_mode = 1;

  initial forever #5 clk = ~clk;

  act_stream_harness #(
    .IN_W(IN_W), .OUT_W(OUT_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(DEP_A),
    .FLUSH_CYCLES(FLUSH_C), .DRAIN_CYCLES(DRAIN_C), .TAIL_CYCLES(TAIL_C)
  ) u_dut_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vectors(num_vectors), .start(start),
    .busy(busy_a), .done(done_a), .dut_valid(valid_a), .dut_flush(flush_a),
    .dut_input_act(act_a), .dut_output_act(out_act), .dut_ready(ready_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_count(cnt_a), .overflow(ovf_a)
  );

  act_stream_harness #(
    .IN_W(IN_W), .OUT_W(OUT_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(DEP_B),
    .FLUSH_CYCLES(FLUSH_C), .DRAIN_CYCLES(DRAIN_C), .TAIL_CYCLES(TAIL_C)
  ) u_dut_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vectors(num_vectors), .start(start),
    .busy(busy_b), .done(done_b), .dut_valid(valid_b), .dut_flush(flush_b),
    .dut_input_act(act_b), .dut_output_act(out_act), .dut_ready(ready_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_count(cnt_b), .overflow(ovf_b)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(bit v, bit f, bit fc, bit b, bit d, logic [IN_W-1:0] a, bit act, bit c);
    exp_t e;
    e.valid = v; e.flush = f; e.fl_chk = fc; e.busy = b; e.done = d;
    e.act = a; e.active = act; e.clr = c;
    return e;
  endfunction

  // Expected run as a plain cycle list: idle, flush, words, drain zeros, tail, done.
  task automatic push_run(input int n);
    expq.push_back(mk(0, 1, 1, 0, 0, '0, 0, 0));
    for (int i = 0; i < FLUSH_C; i++) expq.push_back(mk(0, 1, 1, 1, 0, '0, 0, i == 0));
    for (int k = 0; k < n; k++) expq.push_back(mk(1, 0, 1, 1, 0, model_mem[k], 1, 0));
    for (int i = 0; i < DRAIN_C; i++) expq.push_back(mk(1, 0, 1, 1, 0, '0, 1, 0));
    for (int i = 0; i < TAIL_C; i++) expq.push_back(mk(0, 0, 1, 1, 0, '0, 1, 0));
    expq.push_back(mk(0, 0, 0, 0, 1, '0, 0, 0));
  endtask

  // Per-cycle compare against the expected schedule and capture model.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) ce = expq.pop_front();
      else ce = mk(0, 1, 1, 0, 0, '0, 0, 0);
      if (ce.clr) begin
        mcnt_a = 0; mcnt_b = 0; mov_a = 0; mov_b = 0;
      end
      chk("valid", valid_a, ce.valid);
      if (ce.fl_chk) chk("flush", flush_a, ce.flush);
      chk("input_act", act_a, ce.act);
      chk("busy", busy_a, ce.busy);
      chk("done", done_a, ce.done);
      chk("valid_b", valid_b, ce.valid);
      chk("done_b", done_b, ce.done);
      chk("out_count", cnt_a, mcnt_a);
      chk("overflow", ovf_a, mov_a);
      chk("out_count_b", cnt_b, mcnt_b);
      chk("overflow_b", ovf_b, mov_b);
      if (ce.active) begin
        if (ready_a) begin
          if (mcnt_a < DEP_A) begin cap_a[mcnt_a] = out_act; mcnt_a++; end
          else mov_a = 1;
        end
        if (ready_b) begin
          if (mcnt_b < DEP_B) begin cap_b[mcnt_b] = out_act; mcnt_b++; end
          else mov_b = 1;
        end
      end
    end
  end

  // Stub network: incrementing output word, ready per selected pattern.
  initial begin
    ready_a = 0;
    ready_b = 1;
    out_act = 96'h00A5_0000_0000_F000_0000_0000;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) ready_a = ((rel % 4) == 0);
      else ready_a = 1'($urandom_range(0, 1));
      out_act = out_act + 96'd1;
      rel++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IN_W-1:0] d);
    load_en = 1; load_addr = 10'(a); load_data = d;
    model_mem[a] = d;
    tick();
    load_en = 0;
  endtask

  task automatic run_start(input int n, input bit with_load, input int a, input logic [IN_W-1:0] d);
    if (with_load) begin
      load_en = 1; load_addr = 10'(a); load_data = d;
      model_mem[a] = d;
    end
    num_vectors = 11'(n);
    start = 1;
    rel = 0;
    push_run(n);
    tick();
    start = 0;
    load_en = 0;
  endtask

  task automatic run_wait(output int k, output int vc, output int fc, output bit got);
    k = 0; vc = 0; fc = 0; got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      k++;
      if (valid_a) vc++;
      if (flush_a && busy_a) fc++;
      if (done_a) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
    tick();
  endtask

  task automatic readback(input int na, input int nb);
    for (int a = 0; a < na; a++) begin
      rd_addr_a = 8'(a);
      tick();
      chk("readback_a", rd_data_a, cap_a[a]);
    end
    for (int a = 0; a < nb; a++) begin
      rd_addr_b = 2'(a);
      tick();
      chk("readback_b", rd_data_b, cap_b[a]);
    end
  endtask

  initial begin
    int k, vc, fc, n;
    bit got;
    rst = 1; load_en = 0; load_addr = '0; load_data = '0; start = 0;
    num_vectors = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy", busy_a, 0);
    chk("reset_flush", flush_a, 1);
    chk("reset_valid", valid_a, 0);
    chk("reset_out_count", cnt_a, 0);
    tick();
    rst = 0;
    tick();

    // Directed: words 1..8, ready every 4th cycle.
    for (int i = 0; i < 8; i++) load(i, 16'(i + 1));
    rdy_mode = 0;
    run_start(8, 0, 0, '0);
    run_wait(k, vc, fc, got);
    chk("done_latency_8", k - 1, 91);
    chk("valid_cycles_8", vc, 40);
    chk("flush_cycles_8", fc, 1);
    chk("out_count_every4", cnt_a, 22);
    chk("out_count_b_full", cnt_b, 4);
    chk("overflow_b_set", ovf_b, 1);
    chk("overflow_a_clear", ovf_a, 0);
    readback(mcnt_a, mcnt_b);

    // Zero vectors: flush straight to drain.
    run_start(0, 0, 0, '0);
    run_wait(k, vc, fc, got);
    chk("done_latency_0", k - 1, 83);
    chk("valid_cycles_0", vc, 32);

    // Randomized runs, one loading address 0 in the start cycle.
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 0 : int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) load(i, 16'($urandom));
      run_start(n, r == 1, 0, 16'($urandom));
      run_wait(k, vc, fc, got);
      readback(mcnt_a, mcnt_b);
    end

    // Start during DRAIN and load during FEED must both be ignored.
    for (int i = 0; i < 6; i++) load(i, 16'($urandom));
    run_start(6, 0, 0, '0);
    repeat (2) tick();
    load_en = 1; load_addr = '0; load_data = ~model_mem[0];
    tick();
    load_en = 0;
    repeat (10) tick();
    num_vectors = 11'd3; start = 1;
    tick();
    start = 0;
    run_wait(k, vc, fc, got);
    run_start(6, 0, 0, '0);
    run_wait(k, vc, fc, got);
    chk("done_latency_6", k - 1, 89);
    chk("valid_cycles_6", vc, 38);

    // Reset in the middle of FEED, after the fifth vector.
    for (int i = 0; i < 10; i++) load(i, 16'($urandom));
    run_start(10, 0, 0, '0);
    repeat (5) tick();
    @(negedge clk);
    chk("feed_vec5", act_a, model_mem[4]);
    tick();
    rst = 1;
    expq.delete();
    mcnt_a = 0; mcnt_b = 0; mov_a = 0; mov_b = 0;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_flush", flush_a, 1);
    chk("midrst_out_count", cnt_a, 0);
    tick();
    rst = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    n_miss++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/act_stream_harness.md
Name: act_stream_harness

Overview:
- Synthesizable, parametrised replay/capture harness for the network top: replays a stored activation vector stream into the accelerator and records every output word the accelerator marks ready.
- Flush, feed, drain and tail phases are sequenced automatically; the capture buffer is read back over a simple port.
- Sits beside the network top in FPGA/emulation builds; the same flow runs on silicon without file I/O.

Parameters:
- IN_W, 16, input activation width
- OUT_W, 96, output activation width
- IN_DEPTH, 1024, input vector memory entries
- OUT_DEPTH, 256, capture memory entries
- FLUSH_CYCLES, 1, cycles flush held high before feeding (>=1)
- DRAIN_CYCLES, 32, zero-input valid cycles after the last vector
- TAIL_CYCLES, 50, valid-low cycles kept capturing after drain

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous active-high reset
- load_en  in  1  write strobe into input memory
- load_addr  in  $clog2(IN_DEPTH)  input memory write address
- load_data  in  IN_W  input vector word
- num_vectors  in  $clog2(IN_DEPTH+1)  vectors to replay; sampled at start
- start  in  1  single-cycle run request
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run end
- dut_valid  out  1  to network valid
- dut_flush  out  1  to network flush
- dut_input_act  out  IN_W  to network input_act
- dut_output_act  in  OUT_W  from network output_act
- dut_ready  in  1  from network ready
- rd_addr  in  $clog2(OUT_DEPTH)  capture readback address
- rd_data  out  OUT_W  capture word, 1-cycle read latency
- out_count  out  $clog2(OUT_DEPTH+1)  words captured this run
- overflow  out  1  sticky: a ready word arrived while the buffer was full

Behaviour:
- Reset values: busy=0, done=0, dut_valid=0, dut_flush=1, dut_input_act=0, out_count=0, overflow=0, state=IDLE. rd_data is undefined until the first read.
- Memory contents are not cleared by rst.
- All DUT-side outputs are registered.
- IDLE:
  - dut_flush=1, dut_valid=0.
  - load_en writes the input memory (ignored outside IDLE).
  - start latches num_vectors, clears out_count and overflow, sets busy, then -> FLUSH.
- FLUSH:
  - dut_flush=1 for FLUSH_CYCLES cycles.
  - -> FEED, or -> DRAIN if num_vectors=0.
- FEED:
  - dut_flush=0, dut_valid=1; dut_input_act = mem[k] for k=0..num_vectors-1, one word per cycle, no bubbles.
  - Memory read is pipelined so that word 0 appears in the first FEED cycle.
  - After the last word -> DRAIN.
- DRAIN: dut_valid=1, dut_input_act=0 for DRAIN_CYCLES cycles -> TAIL.
- TAIL: dut_valid=0, dut_input_act=0 for TAIL_CYCLES cycles -> DONE.
- DONE: done=1 for one cycle, busy=0 the same cycle -> IDLE.
- Capture:
  - Active in FEED, DRAIN and TAIL.
  - Each cycle with dut_ready=1: write dut_output_act at address out_count, then out_count+1.
  - At out_count=OUT_DEPTH, further ready words are dropped, out_count holds and overflow sets.
  - dut_ready in IDLE, FLUSH or DONE is ignored.
- start while busy is ignored. start and load_en in the same IDLE cycle: the write completes and the run starts.
- Phase counters are sized for the largest phase, with no wrap. Terminal count is compared exactly, so each phase lasts exactly its parameter value.
- rst mid-run: immediate return to IDLE with reset values; a partial capture remains in memory but out_count=0.
- Readback: rd_data = capture_mem[rd_addr] registered. Reads are legal at any time; a read of an address being written that cycle returns the old data.

Decomposition:
- Package act_harness_pkg holds:
  - state enum: IDLE, FLUSH, FEED, DRAIN, TAIL, DONE
  - counter-width localparam functions
- One sub-module, sdp_ram (parametrised width/depth, 1 write port, 1 registered read port), instantiated twice: input memory and capture memory.

Test Plan:
- Reset mid-FEED (vector 5 of 10) -> next cycle state IDLE, dut_flush=1, dut_valid=0, busy=0, out_count=0.
- Load 8 words 0x0001..0x0008, num_vectors=8, start, defaults -> then:
  - dut_flush high 1 cycle
  - dut_valid high exactly 8+32=40 consecutive cycles with inputs 1..8 then 32 zeros
  - 50 valid-low cycles
  - done pulse exactly 1+40+50 cycles after the start-accept cycle
- Stub DUT drives ready on every 4th cycle with an incrementing 96-bit value -> out_count equals the ready cycles seen in FEED/DRAIN/TAIL; readback addresses 0..out_count-1 match in order.
- OUT_DEPTH=4, ready held high for the whole run -> out_count=4, overflow=1, words 0..3 are the first four values.
- num_vectors=0 -> FLUSH goes straight to DRAIN; 32 valid cycles with zero input; done still pulses.
- start asserted during DRAIN and load_en during FEED -> both ignored; a memory readback shows input contents unchanged.
